// File: rtl/mfp_uart_transmitter_if.sv
// ----------------------------------------------------------------------------
// mfp_uart_transmitter_if : byte write handshake into the UART TX FIFO (rev 1.0)
// ----------------------------------------------------------------------------
`default_nettype none

interface mfp_uart_transmitter_if;
  logic [7:0] byte_data;
  logic       byte_valid;
  logic       byte_ready;

  modport master (output byte_data, output byte_valid, input  byte_ready);
  modport slave  (input  byte_data, input  byte_valid, output byte_ready);
endinterface

`default_nettype wire

// File: rtl/mfp_uart_transmitter.sv
// ----------------------------------------------------------------------------
// mfp_uart_transmitter : FIFO-buffered 8N1/8N2 UART TX; MFP_UART_TX_PARITY_EN adds 8E1/8O1 (rev 1.0)
// ----------------------------------------------------------------------------
`default_nettype none

module mfp_uart_transmitter #(
  parameter int CLOCK_FREQUENCY        = 50000000,
  parameter int BAUD_RATE              = 9600,
  parameter int CLOCK_CYCLES_IN_SYMBOL = CLOCK_FREQUENCY / BAUD_RATE,
  parameter int STOP_BITS              = 1,
  parameter int FIFO_DEPTH             = 4
`ifdef MFP_UART_TX_PARITY_EN
  ,
  parameter bit PARITY_ODD             = 1'b0
`endif
) (
  input  wire logic             clock,
  input  wire logic             reset_n,
  mfp_uart_transmitter_if.slave byte_if,
  output logic                  tx,
  output logic                  busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(CLOCK_CYCLES_IN_SYMBOL);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef MFP_UART_TX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_t;

  logic [7:0]    fifo_mem_q [FIFO_DEPTH];
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  state_t        state_q;
  logic [BW-1:0] baud_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic          tx_q;

  logic          w_empty, w_full, w_push, w_pop;
  logic          w_baud_done, w_last_stop;
  logic [7:0]    w_head;

  // Extra pointer MSB separates full (MSBs differ) from empty (pointers equal).
  assign w_empty     = (wr_ptr_q == rd_ptr_q);
  assign w_full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign w_push      = byte_if.byte_valid && !w_full;
  assign w_baud_done = (baud_q == BW'(CLOCK_CYCLES_IN_SYMBOL - 1));
  assign w_last_stop = (bit_q == 3'(STOP_BITS - 1));
  assign w_head      = fifo_mem_q[rd_ptr_q[AW-1:0]];
  assign w_pop       = !w_empty &&
                       ((state_q == S_IDLE) ||
                        ((state_q == S_STOP) && w_baud_done && w_last_stop));

  assign wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, w_push};
  assign rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, w_pop};

  assign byte_if.byte_ready = !w_full;
  assign tx                 = tx_q;
  assign busy               = (state_q != S_IDLE) || !w_empty;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clock) begin
    if (w_push) begin
      fifo_mem_q[wr_ptr_q[AW-1:0]] <= byte_if.byte_data;
    end
  end

`ifdef MFP_UART_TX_PARITY_EN
  logic parity_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      parity_q <= 1'b0;
    end else if (w_pop) begin
      parity_q <= (^w_head) ^ PARITY_ODD;
    end
  end
`endif

  // tx is registered from the current state, so the line trails the FSM by one clock.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          tx_q <= 1'b1;
          if (w_pop) begin
            shift_q <= w_head;
            baud_q  <= '0;
            bit_q   <= '0;
            state_q <= S_START;
          end
        end
        S_START: begin
          tx_q <= 1'b0;
          if (w_baud_done) begin
            baud_q  <= '0;
            state_q <= S_DATA;
          end else begin
            baud_q <= baud_q + BW'(1);
          end
        end
        S_DATA: begin
          tx_q <= shift_q[0];
          if (w_baud_done) begin
            baud_q  <= '0;
            shift_q <= {1'b0, shift_q[7:1]};
            if (bit_q == 3'd7) begin
              bit_q   <= '0;
`ifdef MFP_UART_TX_PARITY_EN
              state_q <= S_PARITY;
`else
              state_q <= S_STOP;
`endif
            end else begin
              bit_q <= bit_q + 3'd1;
            end
          end else begin
            baud_q <= baud_q + BW'(1);
          end
        end
`ifdef MFP_UART_TX_PARITY_EN
        S_PARITY: begin
          tx_q <= parity_q;
          if (w_baud_done) begin
            baud_q  <= '0;
            bit_q   <= '0;
            state_q <= S_STOP;
          end else begin
            baud_q <= baud_q + BW'(1);
          end
        end
`endif
        S_STOP: begin
          tx_q <= 1'b1;
          if (w_baud_done) begin
            baud_q <= '0;
            if (w_last_stop) begin
              bit_q <= '0;
              // Chaining straight into START keeps queued frames back-to-back.
              if (w_pop) begin
                shift_q <= w_head;
                state_q <= S_START;
              end else begin
                state_q <= S_IDLE;
              end
            end else begin
              bit_q <= bit_q + 3'd1;
            end
          end else begin
            baud_q <= baud_q + BW'(1);
          end
        end
        default: begin
          tx_q    <= 1'b1;
          baud_q  <= '0;
          bit_q   <= '0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mfp_uart_transmitter.sv
// ----------------------------------------------------------------------------
// tb_mfp_uart_transmitter : scoreboard bench for the UART TX (rev 1.0)
// ----------------------------------------------------------------------------
`default_nettype none

module tb_mfp_uart_transmitter;
  localparam int CYC = 10;
`ifdef MFP_UART_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int FL1 = CYC * (1 + 8 + PB + 1);
  localparam int FL2 = CYC * (1 + 8 + PB + 2);

  typedef struct {
    logic [7:0] data;
    logic       par;
    bit         b2b;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_err = 0;
  exp_t       exp_q [3][$];
  logic [7:0] bd [3];
  logic       bv0, bv1, bv2;
  bit         mon_en [3];
  wire        tx0, tx1, tx2, busy0, busy1, busy2, rdy0, rdy1, rdy2;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  mfp_uart_transmitter_if if0 ();
  mfp_uart_transmitter_if if1 ();
  assign if0.byte_data  = bd[0];
  assign if0.byte_valid = bv0;
  assign rdy0           = if0.byte_ready;
  assign if1.byte_data  = bd[1];
  assign if1.byte_valid = bv1;
  assign rdy1           = if1.byte_ready;

  mfp_uart_transmitter #(.CLOCK_FREQUENCY(1000000), .BAUD_RATE(100000),
                         .STOP_BITS(1), .FIFO_DEPTH(4))
    dut0 (.clock(clock), .reset_n(reset_n), .byte_if(if0.slave), .tx(tx0), .busy(busy0));

  mfp_uart_transmitter #(.CLOCK_FREQUENCY(1000000), .BAUD_RATE(100000),
                         .STOP_BITS(2), .FIFO_DEPTH(4))
    dut1 (.clock(clock), .reset_n(reset_n), .byte_if(if1.slave), .tx(tx1), .busy(busy1));

`ifdef MFP_UART_TX_PARITY_EN
  mfp_uart_transmitter_if if2 ();
  assign if2.byte_data  = bd[2];
  assign if2.byte_valid = bv2;
  assign rdy2           = if2.byte_ready;
  mfp_uart_transmitter #(.CLOCK_FREQUENCY(1000000), .BAUD_RATE(100000),
                         .STOP_BITS(1), .FIFO_DEPTH(4), .PARITY_ODD(1'b1))
    dut2 (.clock(clock), .reset_n(reset_n), .byte_if(if2.slave), .tx(tx2), .busy(busy2));
`else
  assign tx2   = 1'b1;
  assign busy2 = 1'b0;
  assign rdy2  = 1'b1;
`endif

  function automatic logic tx_of(input int id);
    case (id)
      0:       return tx0;
      1:       return tx1;
      default: return tx2;
    endcase
  endfunction

  function automatic logic busy_of(input int id);
    case (id)
      0:       return busy0;
      1:       return busy1;
      default: return busy2;
    endcase
  endfunction

  function automatic logic rdy_of(input int id);
    case (id)
      0:       return rdy0;
      1:       return rdy1;
      default: return rdy2;
    endcase
  endfunction

  task automatic set_valid(input int id, input logic v);
    case (id)
      0:       bv0 = v;
      1:       bv1 = v;
      default: bv2 = v;
    endcase
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_frame(input int id, input logic [7:0] d, input logic p, input bit b2b);
    exp_t e;
    e.data = d;
    e.par  = p;
    e.b2b  = b2b;
    exp_q[id].push_back(e);
  endtask

  // Present a burst of bytes on consecutive edges, checking byte_ready each time.
  task automatic write_burst(input int id, input logic [7:0] d [], input logic rdy_exp []);
    for (int i = 0; i < d.size(); i++) begin
      @(negedge clock);
      bd[id] = d[i];
      set_valid(id, 1'b1);
      chk($sformatf("ready[%0d].%0d", id, i), rdy_of(id), rdy_exp[i]);
    end
    @(negedge clock);
    set_valid(id, 1'b0);
  endtask

  task automatic wait_idle(input int id, input int lim);
    int k = 0;
    while (busy_of(id) !== 1'b0 && k < lim) begin
      @(negedge clock);
      k++;
    end
    chk($sformatf("idle_timeout[%0d]", id), 32'(k < lim), 32'd1);
  endtask

  // Receiver model: samples each bit at its centre and checks against the scoreboard.
  task automatic monitor(input int id, input int fl, input int stops);
    int         start;
    int         last = -100000;
    logic [7:0] d;
    logic       p;
    exp_t       e;
    forever begin
      @(negedge clock);
      if (tx_of(id) === 1'b0) begin
        if (!mon_en[id]) begin
          while (tx_of(id) === 1'b0) @(negedge clock);
        end else begin
          start = cyc;
          repeat (CYC / 2) @(negedge clock);
          chk($sformatf("start_bit[%0d]", id), tx_of(id), 1'b0);
          for (int i = 0; i < 8; i++) begin
            repeat (CYC) @(negedge clock);
            d[i] = tx_of(id);
          end
          p = 1'b0;
`ifdef MFP_UART_TX_PARITY_EN
          repeat (CYC) @(negedge clock);
          p = tx_of(id);
`endif
          for (int s = 0; s < stops; s++) begin
            repeat (CYC) @(negedge clock);
            chk($sformatf("stop_bit[%0d].%0d", id, s), tx_of(id), 1'b1);
          end
          if (exp_q[id].size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_frame[%0d]: got %02h expected no frame", id, d);
          end else begin
            e = exp_q[id].pop_front();
            chk($sformatf("data[%0d]", id), d, e.data);
`ifdef MFP_UART_TX_PARITY_EN
            chk($sformatf("parity[%0d]", id), p, e.par);
`endif
            if (e.b2b) chk($sformatf("spacing[%0d]", id), start - last, fl);
          end
          last = start;
        end
      end
    end
  endtask

  initial begin
    fork
      monitor(0, FL1, 1);
      monitor(1, FL2, 2);
      monitor(2, FL1, 1);
    join_none
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    for (int i = 0; i < 3; i++) begin
      bd[i]     = 8'h00;
      mon_en[i] = 1'b1;
    end
    bv0 = 1'b0;
    bv1 = 1'b0;
    bv2 = 1'b0;

    repeat (3) @(negedge clock);
    chk("rst_tx", tx0, 1'b1);
    chk("rst_busy", busy0, 1'b0);
    chk("rst_ready", rdy0, 1'b1);
    reset_n = 1'b1;

    // Idle line after reset
    repeat (200) begin
      @(negedge clock);
      chk("idle0", {tx0, busy0, rdy0}, 3'b101);
      chk("idle1", {tx1, busy1, rdy1}, 3'b101);
    end

    // Single byte: latency and frame length
    expect_frame(0, 8'hA5, 1'b0, 1'b0);
    @(negedge clock);
    bd[0] = 8'hA5;
    bv0   = 1'b1;
    chk("a5_ready", rdy0, 1'b1);
    @(negedge clock);
    bv0 = 1'b0;
    chk("lat_n0", tx0, 1'b1);
    @(negedge clock);
    chk("lat_n1", tx0, 1'b1);
    @(negedge clock);
    chk("lat_n2", tx0, 1'b0);
    repeat (FL1 - 7) @(negedge clock);
    chk("a5_busy_mid", busy0, 1'b1);
    repeat (7) @(negedge clock);
    chk("a5_busy_end", busy0, 1'b0);
    chk("a5_tx_end", tx0, 1'b1);

    // Burst fills the FIFO; sixth byte refused
    expect_frame(0, 8'h01, 1'b1, 1'b0);
    expect_frame(0, 8'h80, 1'b1, 1'b1);
    expect_frame(0, 8'hFF, 1'b0, 1'b1);
    expect_frame(0, 8'h00, 1'b0, 1'b1);
    expect_frame(0, 8'h55, 1'b0, 1'b1);
    write_burst(0, '{8'h01, 8'h80, 8'hFF, 8'h00, 8'h55, 8'hEE},
                   '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0});
    chk("full_hold", rdy0, 1'b0);
    wait_idle(0, 800);

    // Reset during a frame with bytes queued
    mon_en[0] = 1'b0;
    write_burst(0, '{8'h3C, 8'h11, 8'h22}, '{1'b1, 1'b1, 1'b1});
    k = 0;
    while (tx0 !== 1'b0 && k < 20) begin
      @(negedge clock);
      k++;
    end
    chk("3c_start_seen", 32'(k < 20), 32'd1);
    repeat (CYC * 4 + CYC / 2) @(negedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_tx", tx0, 1'b1);
    chk("async_busy", busy0, 1'b0);
    chk("async_ready", rdy0, 1'b1);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    repeat (300) begin
      @(negedge clock);
      chk("post_rst", {tx0, busy0}, 2'b10);
    end
    mon_en[0] = 1'b1;

    // Two stop bits
    expect_frame(1, 8'h0F, 1'b0, 1'b0);
    expect_frame(1, 8'hF0, 1'b0, 1'b1);
    write_burst(1, '{8'h0F, 8'hF0}, '{1'b1, 1'b1});
    wait_idle(1, 400);

`ifdef MFP_UART_TX_PARITY_EN
    expect_frame(0, 8'h07, 1'b1, 1'b0);
    expect_frame(0, 8'h03, 1'b0, 1'b1);
    write_burst(0, '{8'h07, 8'h03}, '{1'b1, 1'b1});
    wait_idle(0, 400);
    expect_frame(2, 8'h07, 1'b0, 1'b0);
    write_burst(2, '{8'h07}, '{1'b1});
    wait_idle(2, 400);
`endif

    repeat (20) @(negedge clock);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("leftover[%0d]", i), exp_q[i].size(), 32'd0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mfp_uart_transmitter.md
Name: mfp_uart_transmitter

Overview:
Serial UART transmitter. It is the TX companion of the calculator's UART receiver and sends result bytes back to the host. Bytes arrive through a valid/ready handshake and are buffered in a small FIFO. They leave on `tx` as 8N1 (or 8N2) frames, LSB first, at a fixed baud rate derived from the system clock.

Parameters:
clock_frequency, 50000000, system clock in Hz
baud_rate, 9600, serial bit rate
clock_cycles_in_symbol, clock_frequency / baud_rate, clocks per serial bit (derived; >= 2)
stop_bits, 1, number of stop bits (1 or 2)
fifo_depth, 4, byte FIFO entries (power of two, >= 2)

Ports:
clock  input  1  system clock, all logic on posedge
reset_n  input  1  asynchronous active-low reset
byte_data  input  8  byte to send
byte_valid  input  1  byte_data valid this cycle
byte_ready  output  1  FIFO can accept a byte (not full)
tx  output  1  serial line, idle high
busy  output  1  frame in progress or FIFO non-empty

Behaviour:
- Interface (decided): one clock, `clock`. Reset is `reset_n`, asynchronous and active-low.
- Reset values:
  - tx = 1, busy = 0, byte_ready = 1.
  - FIFO empty; FSM in IDLE; baud and bit counters at 0.
- Reset asserted mid-frame: tx returns to 1 immediately (asynchronously); buffered bytes are discarded.
- Write handshake:
  - A byte is accepted on a posedge where byte_valid && byte_ready.
  - byte_ready = !full, taken from registered FIFO state.
  - byte_ready stays low when full, even if a pop occurs in the same cycle; no bypass.
- FIFO:
  - Circular buffer; read and write pointers are log2(fifo_depth)+1 bits wide so full and empty can be told apart.
  - Pointers wrap modulo 2*fifo_depth.
  - Simultaneous push and pop in the same cycle is legal; occupancy is unchanged.
- FSM states: IDLE, START, DATA, PARITY (optional), STOP.
  - IDLE: when the FIFO is non-empty, pop the head into an 8-bit shift register and go to START.
    - Latency: a byte written at edge N into an empty FIFO with the FSM in IDLE makes tx fall at edge N+2.
  - START: tx = 0 for clock_cycles_in_symbol cycles, then go to DATA.
  - DATA: tx = shift[0]; shift right once per bit period; bit counter runs 0..7.
    - After bit 7, go to PARITY if enabled, else STOP.
  - STOP: tx = 1 for stop_bits * clock_cycles_in_symbol cycles.
    - At the end: if the FIFO is non-empty, pop and enter START directly, giving back-to-back frames with no extra idle bits. Otherwise go to IDLE.
- Baud counter: counts 0..clock_cycles_in_symbol-1, resets to 0 on every state change, and marks the end of a bit at terminal count. Every bit lasts exactly clock_cycles_in_symbol clocks; no drift.
- tx is registered; no combinational path from inputs to tx.
- busy = (state != IDLE) || !empty.
- byte_valid while byte_ready = 0: the byte is ignored and nothing is stored. The sender must hold the byte until ready.

Optional Feature:
Macro: MFP_UART_TX_PARITY_EN
- Defined:
  - Adds parameter parity_odd (default 0).
  - After DATA the FSM enters PARITY for one bit period.
  - The parity bit is XOR of the 8 data bits, inverted when parity_odd = 1.
  - Frame becomes 8E1/8O1 (with stop_bits = 1).
- Not defined: the PARITY state and its logic are absent; frames are 8N1/8N2.

Test Plan:
Bench settings: clock_frequency = 1000000, baud_rate = 100000 (10 clocks/bit), stop_bits = 1, fifo_depth = 4, unless noted.
1. Reset, no writes for 200 cycles -> tx = 1, busy = 0, byte_ready = 1 throughout.
2. Write 8'hA5 at edge N -> tx falls at N+2. Bits sampled mid-bit read 0,1,0,1,0,0,1,0,1 then stop = 1. Frame lasts 100 clocks, then busy = 0.
3. Write 8'h01, 8'h80, 8'hFF, 8'h00, 8'h55 on consecutive cycles:
   - First 5 writes accepted (one entry is popped at edge N+1, freeing space).
   - byte_ready = 0 while full; a 6th write is ignored.
   - Receiver model decodes exactly 01,80,FF,00,55 with 10-clock stop bits and no gaps.
4. Assert reset_n low at the 4th data bit of 8'h3C with 2 bytes queued -> tx = 1 immediately. After release: FIFO empty, no further frames.
5. stop_bits = 2, write 8'h0F then 8'hF0 -> 20-clock stop between frames; both bytes decoded correctly.
6. With MFP_UART_TX_PARITY_EN defined:
   - parity_odd = 0: 8'h07 -> parity bit 1; 8'h03 -> parity bit 0.
   - parity_odd = 1: 8'h07 -> parity bit 0.
   - Frame length 110 clocks.
